// File: rtl/craps_multi_if.sv
// Dice-board bus for craps_multi: roll button in, dice/point/shooter/status/tallies out.
interface craps_multi_if #(
  parameter int NPLAYERS = 2,
  parameter int SW       = 4
);
  logic                   rb;
  logic [3:0]             die1;
  logic [3:0]             die2;
  logic [4:0]             sum;
  logic [4:0]             point;
  logic [1:0]             player;
  logic                   roll;
  logic                   win;
  logic                   lose;
  logic [NPLAYERS*SW-1:0] wins;
  logic [NPLAYERS*SW-1:0] losses;

  modport master (output rb,
                  input  die1, die2, sum, point, player, roll, win, lose, wins, losses);
  modport slave  (input  rb,
                  output die1, die2, sum, point, player, roll, win, lose, wins, losses);
endinterface

// File: rtl/craps_multi.sv
// Multi-player craps controller: free-running dice, come-out/point FSM, shooter rotation.
// Per-player win/loss tallies are built only when CRAPS_STATS_EN is defined.
module craps_multi #(
  parameter int SIDES    = 6,
  parameter int NPLAYERS = 2,
  parameter int SW       = 4
) (
  input  logic        clk,
  input  logic        reset,
  craps_multi_if.slave bus
);
  typedef enum logic [2:0] {S0, SROLL1, SPOINT, SROLL2, SWIN, SLOSE} state_t;

  localparam logic [3:0] SMAX = 4'(SIDES);
  localparam logic [4:0] NAT1 = 5'(SIDES + 1);
  localparam logic [4:0] NAT2 = 5'(2*SIDES - 1);
  localparam logic [4:0] CR12 = 5'(2*SIDES);
  localparam logic [1:0] PMAX = 2'(NPLAYERS - 1);

  state_t     state, nxt;
  logic [3:0] die1, die2;
  logic [4:0] sum, point;
  logic [1:0] player;
  logic       load_pt, new_game, is_nat, is_craps;

  assign sum      = {1'b0, die1} + {1'b0, die2};
  assign is_nat   = (sum == NAT1) || (sum == NAT2);
  assign is_craps = (sum == 5'd2) || (sum == 5'd3) || (sum == CR12);

  always_comb begin
    nxt      = state;
    load_pt  = 1'b0;
    new_game = 1'b0;
    case (state)
      S0:     if (bus.rb) nxt = SROLL1;
      SROLL1: if (!bus.rb) begin
        if (is_nat)        nxt = SWIN;
        else if (is_craps) nxt = SLOSE;
        else begin
          nxt     = SPOINT;
          load_pt = 1'b1;
        end
      end
      SPOINT: if (bus.rb) nxt = SROLL2;
      SROLL2: if (!bus.rb) begin
        if (sum == point)     nxt = SWIN;
        else if (sum == NAT1) nxt = SLOSE;
        else                  nxt = SPOINT;
      end
      SWIN, SLOSE: if (bus.rb) begin
        nxt      = SROLL1;
        new_game = 1'b1;
      end
      default: nxt = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S0;
      die1   <= 4'd1;
      die2   <= 4'd1;
      point  <= 5'd0;
      player <= 2'd0;
    end else begin
      state <= nxt;
      // dice free-run on rb regardless of state; die2 steps on die1's wrap
      if (bus.rb) begin
        if (die1 == SMAX) begin
          die1 <= 4'd1;
          die2 <= (die2 == SMAX) ? 4'd1 : die2 + 4'd1;
        end else begin
          die1 <= die1 + 4'd1;
        end
      end
      if (load_pt) point <= sum;
      if (new_game) begin
        point  <= 5'd0;
        player <= (player == PMAX) ? 2'd0 : player + 2'd1;
      end
    end
  end

`ifdef CRAPS_STATS_EN
  logic [NPLAYERS-1:0][SW-1:0] wcnt, lcnt;
  logic win_e, lose_e;

  // only SROLL1/SROLL2 can step into SWIN/SLOSE, so entry = next is the terminal state
  assign win_e  = (nxt == SWIN)  && (state != SWIN);
  assign lose_e = (nxt == SLOSE) && (state != SLOSE);

  for (genvar p = 0; p < NPLAYERS; p++) begin : g_stat
    always_ff @(posedge clk) begin
      if (reset) begin
        wcnt[p] <= '0;
        lcnt[p] <= '0;
      end else if (player == 2'(p)) begin
        if (win_e  && (wcnt[p] != '1)) wcnt[p] <= wcnt[p] + 1'b1;
        if (lose_e && (lcnt[p] != '1)) lcnt[p] <= lcnt[p] + 1'b1;
      end
    end
  end

  assign bus.wins   = wcnt;
  assign bus.losses = lcnt;
`else
  assign bus.wins   = '0;
  assign bus.losses = '0;
`endif

  assign bus.die1   = die1;
  assign bus.die2   = die2;
  assign bus.sum    = sum;
  assign bus.point  = point;
  assign bus.player = player;
  assign bus.roll   = (state == SROLL1) || (state == SROLL2);
  assign bus.win    = (state == SWIN);
  assign bus.lose   = (state == SLOSE);
endmodule
